// File: rtl/maze_carver_dfs.sv
// Recursive-backtracker maze carver: explicit room stack plus a free-running LFSR pick a perfect maze.
// Optional build macro MAZE_CARVER_EXITS_EN opens an entrance (0,1) and exit (W-1,H-2) on entry to DONE.
module maze_carver_dfs #(
  parameter int          MAZE_W    = 15,
  parameter int          MAZE_H    = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       seed_load,
  input  logic [15:0]                seed,
  input  logic [5:0]                 start_x,
  input  logic [5:0]                 start_y,
  output logic [MAZE_W*MAZE_H-1:0]   maze_data,
  output logic                       busy,
  output logic                       finish,
  output logic [11:0]                cells_carved
);

  localparam int RW    = (MAZE_W - 1) / 2;
  localparam int RH    = (MAZE_H - 1) / 2;
  localparam int N     = RW * RH;
  localparam int CELLS = MAZE_W * MAZE_H;
  localparam int IW    = $clog2(CELLS);
  localparam int SPW   = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STEP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CELLS-1:0] grid_q, grid_d;
  logic [5:0]       cx_q, cx_d, cy_q, cy_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [11:0]      stack_q [N];
  logic [15:0]      lfsr_q, lfsr_d, lfsr_adv_s;
  logic [11:0]      carved_q, carved_d;
  logic             busy_q, finish_q, push_s;

  logic [5:0]       nx_s [4];
  logic [5:0]       ny_s [4];
  logic [IW-1:0]    room_idx_s [4];
  logic [IW-1:0]    wall_idx_s [4];
  logic [3:0]       ok_s, mask_s;
  logic [1:0]       scan_s, pick_s;
  logic             found_s;

  function automatic logic [IW-1:0] cell_idx(input logic [6:0] x, input logic [6:0] y);
    return IW'(x) + IW'(y) * IW'(MAZE_W);
  endfunction

  assign lfsr_adv_s = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Neighbour rooms (0=up 1=right 2=down 3=left); the wall cell sits midway between the two rooms.
  always_comb begin
    nx_s[0] = cx_q;         ny_s[0] = cy_q - 6'd1; ok_s[0] = (cy_q != 6'd0);
    nx_s[1] = cx_q + 6'd1;  ny_s[1] = cy_q;        ok_s[1] = (cx_q != 6'(RW - 1));
    nx_s[2] = cx_q;         ny_s[2] = cy_q + 6'd1; ok_s[2] = (cy_q != 6'(RH - 1));
    nx_s[3] = cx_q - 6'd1;  ny_s[3] = cy_q;        ok_s[3] = (cx_q != 6'd0);
    for (int d = 0; d < 4; d++) begin
      room_idx_s[d] = cell_idx({nx_s[d], 1'b1}, {ny_s[d], 1'b1});
      wall_idx_s[d] = cell_idx(7'(cx_q) + 7'(nx_s[d]) + 7'd1, 7'(cy_q) + 7'(ny_s[d]) + 7'd1);
      mask_s[d]     = ok_s[d] & ~grid_q[room_idx_s[d]];
    end
  end

  // First open direction scanning from lfsr[1:0] upward, modulo 4.
  always_comb begin
    found_s = 1'b0;
    pick_s  = 2'd0;
    scan_s  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_s = lfsr_q[1:0] + 2'(k);
      if (!found_s && mask_s[scan_s]) begin
        found_s = 1'b1;
        pick_s  = scan_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the carving FSM.
  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    sp_d     = sp_q;
    carved_d = carved_q;
    push_s   = 1'b0;
    lfsr_d   = lfsr_adv_s;
    case (state_q)
      S_IDLE, S_DONE: begin
        lfsr_d = seed_load ? ((seed == 16'd0) ? LFSR_SEED : seed) : lfsr_adv_s;
        if (start) begin
          state_d = S_CLEAR;
          cx_d    = (start_x < 6'(RW)) ? start_x : 6'd0;
          cy_d    = (start_y < 6'(RH)) ? start_y : 6'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_CLEAR: begin
        grid_d = '0;
        grid_d[cell_idx({cx_q, 1'b1}, {cy_q, 1'b1})] = 1'b1;
        sp_d     = '0;
        carved_d = 12'd1;
        state_d  = S_STEP;
      end
      S_STEP: begin
        if (found_s) begin
          grid_d[wall_idx_s[pick_s]] = 1'b1;
          grid_d[room_idx_s[pick_s]] = 1'b1;
          push_s   = 1'b1;
          sp_d     = sp_q + SPW'(1);
          cx_d     = nx_s[pick_s];
          cy_d     = ny_s[pick_s];
          carved_d = carved_q + 12'd1;
        end else if (sp_q != SPW'(0)) begin
          sp_d         = sp_q - SPW'(1);
          {cx_d, cy_d} = stack_q[sp_q - SPW'(1)];
        end else begin
          state_d = S_DONE;
`ifdef MAZE_CARVER_EXITS_EN
          grid_d[IW'(MAZE_W)] = 1'b1;
          grid_d[IW'(MAZE_W - 1 + (MAZE_H - 2) * MAZE_W)] = 1'b1;
`else
          grid_d = grid_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; busy/finish trail the state by one edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grid_q   <= '0;
      cx_q     <= 6'd0;
      cy_q     <= 6'd0;
      sp_q     <= '0;
      carved_q <= 12'd0;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      sp_q     <= sp_d;
      carved_q <= carved_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= (state_q == S_CLEAR) || (state_q == S_STEP);
      finish_q <= (state_q == S_DONE);
    end
  end

  // Backtrack stack storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_q[sp_q] <= {cx_q, cy_q};
    end
  end

  assign maze_data    = grid_q;
  assign busy         = busy_q;
  assign finish       = finish_q;
  assign cells_carved = carved_q;

endmodule

// File: doc/maze_carver_dfs.md
# maze_carver_dfs

Parametrised depth-first (recursive-backtracker) maze generator for the maze game datapath, and the successor to the fixed 16x16 carver. It carves a perfect maze into a flat W×H bit grid using an explicit on-chip stack and an internal LFSR. Termination is guaranteed and the cycle count is deterministic. The grid output feeds the renderer/collision logic directly, and `finish` hands control to the game FSM.

## Interface
- `MAZE_W`, default 15: grid width in cells. Must be odd, 5..63.
- `MAZE_H`, default 15: grid height in cells. Must be odd, 5..63.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. It also replaces any zero seed.
- Derived values:
  - RW=(MAZE_W-1)/2 and RH=(MAZE_H-1)/2 are the room counts.
  - N=RW*RH is the total room count.
  - Stack depth is N.
- `clk`: input, 1 bit. Single clock; all logic is rising-edge.
- `reset`: input, 1 bit. Synchronous, active-low (0 = reset).
- `start`: input, 1 bit. Begins generation. Sampled only in IDLE or DONE.
- `seed_load`: input, 1 bit. Loads `seed` into the LFSR. Honoured only in IDLE or DONE.
- `seed`: input, 16 bits. LFSR seed value.
- `start_x`: input, 6 bits. Starting room column, 0..RW-1.
- `start_y`: input, 6 bits. Starting room row, 0..RH-1.
- `maze_data`: output, MAZE_W*MAZE_H bits. Bit x+y*MAZE_W is set to 1 for path and 0 for wall.
- `busy`: output, 1 bit. High during CLEAR and STEP.
- `finish`: output, 1 bit. High in DONE.
- `cells_carved`: output, 12 bits. Count of rooms carved so far.

## Operation
- Room (i,j) is grid cell (2i+1, 2j+1). Even-coordinate cells are walls or posts. The outer border is never carved, unless the configuration macro in Configuration is defined.
- FSM states: IDLE, CLEAR, STEP, DONE.
- IDLE / DONE, when `start`=1:
  - Latch the start room.
  - Any out-of-range coordinate is replaced by 0.
  - Go to CLEAR.
- CLEAR (1 cycle):
  - `maze_data` is all 0.
  - Set the start room bit.
  - Set stack pointer sp=0 and `cells_carved`=1.
  - Go to STEP.
- STEP (1 cycle per move):
  - Form a 4-bit candidate mask over directions 0=up (y-2), 1=right, 2=down, 3=left.
  - A bit is set if the room two cells away is in-grid and its bit is 0.
  - If the mask is nonzero:
    - Let r = lfsr[1:0]. Choose the first set bit scanning r, r+1, … mod 4.
    - Set the intervening wall bit and the target room bit.
    - Push the current room (stack[sp] ← cur; sp+1).
    - Move to the target and increment `cells_carved`.
  - If the mask is zero and sp>0: pop (sp−1, cur ← stack[sp−1]). The grid is unchanged.
  - If the mask is zero and sp=0: go to DONE.
- DONE:
  - `finish`=1 and `maze_data` is held.
  - A new `start` restarts via CLEAR, without needing a reset.
- `start` during CLEAR or STEP is ignored.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle in every state.
- Stack entries are {x,y} room indices (6+6 bits). sp is never exceeded because every push carves a new room.
- Reset (any state, including mid-STEP):
  - State IDLE, `maze_data`=0.
  - `busy`=0, `finish`=0, `cells_carved`=0.
  - sp=0, lfsr=LFSR_SEED.

## Timing
- The edge that samples `start` enters CLEAR. `busy` is high from the next cycle.
- STEP occupies exactly 2N−1 cycles: N−1 pushes, N−1 pops, and one final empty check.
- `finish` rises exactly 2N+1 cycles after the `start`-sampling edge. `busy` falls on the same edge.
- In the default configuration (N=49), `finish` rises at 99 cycles.
- `maze_data` changes only on CLEAR and carving STEP edges. It is stable whenever `finish`=1.
- `seed_load` and `start` asserted on the same cycle: the seed is loaded and generation begins. The first STEP uses the LFSR advanced from the new seed.

## Configuration
- `MAZE_CARVER_EXITS_EN`
  - Defined: on entry to DONE, two extra bits are set in the same cycle: entrance cell (0,1) and exit cell (MAZE_W−1, MAZE_H−2).
  - Undefined: the border remains all 0.
  - Cycle counts are identical either way.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release → `maze_data`=0, `finish`=0, `busy`=0, `cells_carved`=0.
- MAZE_W=MAZE_H=5, start (0,0):
  - `finish` rises at cycle 9.
  - `maze_data` has exactly 7 ones: 4 rooms and 3 walls.
  - The border is all 0 and `cells_carved`=4.
- Default 15×15, seed 16'h1234:
  - `finish` rises at cycle 99 with `cells_carved`=49.
  - The bench flood-fills the grid: all 49 rooms are connected and there are exactly 97 path bits (a perfect tree).
  - Rerunning with the same seed gives an identical bitmap.
- Start (9,9) on 15×15 is treated as (0,0), so room (1,1) is set in CLEAR.
- Reset at STEP cycle 20 → IDLE with a cleared grid. A following `start` completes normally in 99 cycles.
- With `MAZE_CARVER_EXITS_EN`, 15×15 → bits (0,1) and (14,13) are set at `finish`, giving 99 path bits total.
